// File: rtl/icache_mshr_file.sv
// Instruction-cache miss status holding registers: tracks outstanding line misses,
// merges secondary misses onto a pending primary, and replays fill data to every waiter.
module icache_mshr_file #(
    parameter int ENTRY_NUM   = 8,
    parameter int TAG_WIDTH   = 17,
    parameter int INDEX_WIDTH = 9,
    parameter int TXNID_WIDTH = 5,
    parameter int WAY_NUM     = 2,
    parameter int DATA_WIDTH  = 512,
    parameter int MERGE_EN    = 1,
    localparam int EIW = $clog2(ENTRY_NUM),
    localparam int WW  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    localparam int OW  = $clog2(ENTRY_NUM + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_vld,
    output logic                             alloc_rdy,
    input  logic [TAG_WIDTH-1:0]             alloc_tag,
    input  logic [INDEX_WIDTH-1:0]           alloc_index,
    input  logic [TXNID_WIDTH-1:0]           alloc_txnid,
    input  logic [WW-1:0]                    alloc_way,
    output logic                             dreq_vld,
    input  logic                             dreq_rdy,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] dreq_addr,
    output logic [EIW-1:0]                   dreq_id,
    input  logic                             fill_vld,
    output logic                             fill_rdy,
    input  logic [EIW-1:0]                   fill_id,
    input  logic [DATA_WIDTH-1:0]            fill_data,
    output logic                             fill_err,
    output logic                             resp_vld,
    input  logic                             resp_rdy,
    output logic [TXNID_WIDTH-1:0]           resp_txnid,
    output logic [INDEX_WIDTH-1:0]           resp_index,
    output logic [WW-1:0]                    resp_way,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic [OW-1:0]                    occupancy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_REQ, ST_WAIT_FILL, ST_RESP} st_e;

    typedef struct packed {
        logic                   vld;
        logic [TAG_WIDTH-1:0]   tag;
        logic [INDEX_WIDTH-1:0] idx;
        logic [TXNID_WIDTH-1:0] txn;
        logic [WW-1:0]          way;
        logic                   pri;
        logic [EIW-1:0]         par;
        st_e                    st;
    } ent_t;

    ent_t                  r_ent [ENTRY_NUM];
    logic                  r_fb_vld;
    logic [DATA_WIDTH-1:0] r_fb_data;
    logic                  r_ferr;

    logic           w_any_idle, w_merge_hit, w_dreq_any, w_resp_any;
    logic [EIW-1:0] w_alloc_sel, w_merge_sel, w_dreq_sel, w_resp_sel;
    logic [OW-1:0]  w_resp_cnt, w_occ;
    logic           w_alloc_hs, w_dreq_hs, w_resp_hs, w_fill_hs, w_fill_ok, w_fill_acc;

    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        w_any_idle  = 1'b0;
        w_alloc_sel = '0;
        w_merge_hit = 1'b0;
        w_merge_sel = '0;
        w_dreq_any  = 1'b0;
        w_dreq_sel  = '0;
        w_resp_any  = 1'b0;
        w_resp_sel  = '0;
        w_resp_cnt  = '0;
        w_occ       = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (r_ent[i].st == ST_IDLE) begin
                w_any_idle  = 1'b1;
                w_alloc_sel = EIW'(i);
            end
            if ((MERGE_EN != 0) && r_ent[i].vld && r_ent[i].pri &&
                (r_ent[i].st == ST_WAIT_REQ || r_ent[i].st == ST_WAIT_FILL) &&
                r_ent[i].tag == alloc_tag && r_ent[i].idx == alloc_index) begin
                w_merge_hit = 1'b1;
                w_merge_sel = EIW'(i);
            end
            if (r_ent[i].pri && r_ent[i].st == ST_WAIT_REQ) begin
                w_dreq_any = 1'b1;
                w_dreq_sel = EIW'(i);
            end
            if (r_ent[i].st == ST_RESP) begin
                w_resp_any = 1'b1;
                w_resp_sel = EIW'(i);
                w_resp_cnt = w_resp_cnt + OW'(1);
            end
            w_occ = w_occ + OW'(r_ent[i].vld);
        end
    end

    assign w_alloc_hs = alloc_vld && w_any_idle;
    assign w_dreq_hs  = w_dreq_any && dreq_rdy;
    assign w_resp_hs  = w_resp_any && resp_rdy;
    assign w_fill_hs  = fill_vld && !r_fb_vld;
    assign w_fill_ok  = r_ent[fill_id].vld && r_ent[fill_id].pri && r_ent[fill_id].st == ST_WAIT_FILL;
    assign w_fill_acc = w_fill_hs && w_fill_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) r_ent[i] <= '0;
            r_fb_vld  <= 1'b0;
            r_fb_data <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_ferr <= w_fill_hs && !w_fill_ok;
            if (w_fill_acc) begin
                r_fb_vld  <= 1'b1;
                r_fb_data <= fill_data;
            end else if (w_resp_hs && w_resp_cnt == OW'(1)) begin
                r_fb_vld <= 1'b0;
            end
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (w_dreq_hs && w_dreq_sel == EIW'(i))
                    r_ent[i].st <= ST_WAIT_FILL;
                if (w_fill_acc && r_ent[i].st == ST_WAIT_FILL &&
                    (EIW'(i) == fill_id || (!r_ent[i].pri && r_ent[i].par == fill_id)))
                    r_ent[i].st <= ST_RESP;
                if (w_resp_hs && w_resp_sel == EIW'(i)) begin
                    r_ent[i].st  <= ST_IDLE;
                    r_ent[i].vld <= 1'b0;
                end
                if (w_alloc_hs && w_alloc_sel == EIW'(i)) begin
                    r_ent[i].vld <= 1'b1;
                    r_ent[i].tag <= alloc_tag;
                    r_ent[i].idx <= alloc_index;
                    r_ent[i].txn <= alloc_txnid;
                    r_ent[i].way <= alloc_way;
                    r_ent[i].pri <= !w_merge_hit;
                    r_ent[i].par <= w_merge_sel;
                    // A secondary joining a primary whose fill lands this cycle rides the same fill.
                    if (!w_merge_hit)
                        r_ent[i].st <= ST_WAIT_REQ;
                    else if (w_fill_acc && fill_id == w_merge_sel)
                        r_ent[i].st <= ST_RESP;
                    else
                        r_ent[i].st <= ST_WAIT_FILL;
                end
            end
        end
    end

    assign alloc_rdy  = w_any_idle;
    assign dreq_vld   = w_dreq_any;
    assign dreq_addr  = w_dreq_any ? {r_ent[w_dreq_sel].tag, r_ent[w_dreq_sel].idx} : '0;
    assign dreq_id    = w_dreq_sel;
    assign fill_rdy   = !r_fb_vld;
    assign fill_err   = r_ferr;
    assign resp_vld   = w_resp_any;
    assign resp_txnid = w_resp_any ? r_ent[w_resp_sel].txn : '0;
    assign resp_index = w_resp_any ? r_ent[w_resp_sel].idx : '0;
    assign resp_way   = w_resp_any ? r_ent[w_resp_sel].way : '0;
    assign resp_data  = w_resp_any ? r_fb_data : '0;
    assign occupancy  = w_occ;

endmodule

// File: tb/tb_icache_mshr_file.sv
// Directed bench for icache_mshr_file: inputs driven and outputs sampled on the falling edge.
module tb_icache_mshr_file;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_vld, alloc_rdy;
    logic [16:0]  alloc_tag;
    logic [8:0]   alloc_index;
    logic [4:0]   alloc_txnid;
    logic [0:0]   alloc_way;
    logic         dreq_vld, dreq_rdy;
    logic [25:0]  dreq_addr;
    logic [2:0]   dreq_id;
    logic         fill_vld, fill_rdy;
    logic [2:0]   fill_id;
    logic [511:0] fill_data;
    logic         fill_err;
    logic         resp_vld, resp_rdy;
    logic [4:0]   resp_txnid;
    logic [8:0]   resp_index;
    logic [0:0]   resp_way;
    logic [511:0] resp_data;
    logic [3:0]   occupancy;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    icache_mshr_file dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_tag(alloc_tag),
        .alloc_index(alloc_index), .alloc_txnid(alloc_txnid), .alloc_way(alloc_way),
        .dreq_vld(dreq_vld), .dreq_rdy(dreq_rdy), .dreq_addr(dreq_addr), .dreq_id(dreq_id),
        .fill_vld(fill_vld), .fill_rdy(fill_rdy), .fill_id(fill_id), .fill_data(fill_data),
        .fill_err(fill_err), .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_txnid(resp_txnid),
        .resp_index(resp_index), .resp_way(resp_way), .resp_data(resp_data), .occupancy(occupancy)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_alloc(input logic [16:0] tag, input logic [8:0] idx, input logic [4:0] txn, input logic w);
        alloc_vld = 1'b1; alloc_tag = tag; alloc_index = idx; alloc_txnid = txn; alloc_way = w;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        n_vec++; if (alloc_rdy !== 1'b1) begin n_mis++; $display("FAIL rst_alloc_rdy got %b exp 1", alloc_rdy); end
        n_vec++; if (fill_rdy !== 1'b1) begin n_mis++; $display("FAIL rst_fill_rdy got %b exp 1", fill_rdy); end
        n_vec++; if (dreq_vld !== 1'b0) begin n_mis++; $display("FAIL rst_dreq_vld got %b exp 0", dreq_vld); end
        n_vec++; if (resp_vld !== 1'b0) begin n_mis++; $display("FAIL rst_resp_vld got %b exp 0", resp_vld); end
        n_vec++; if (fill_err !== 1'b0) begin n_mis++; $display("FAIL rst_fill_err got %b exp 0", fill_err); end
        n_vec++; if (occupancy !== 4'd0) begin n_mis++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
        n_vec++; if (dreq_addr !== 26'd0 || resp_data !== 512'd0) begin n_mis++; $display("FAIL rst_data got addr %h exp 0", dreq_addr); end
        rst = 1'b0;
    endtask

    task automatic test_single_miss;
        logic [511:0] d;
        d = {16{32'hCAFE0001}};
        set_alloc(17'h1A, 9'd5, 5'd3, 1'b1);
        tick();
        alloc_vld = 1'b0;
        n_vec++; if (dreq_vld !== 1'b1) begin n_mis++; $display("FAIL sm_dreq_vld got %b exp 1", dreq_vld); end
        n_vec++; if (dreq_addr !== {17'h1A, 9'd5}) begin n_mis++; $display("FAIL sm_dreq_addr got %h exp %h", dreq_addr, {17'h1A, 9'd5}); end
        n_vec++; if (dreq_id !== 3'd0) begin n_mis++; $display("FAIL sm_dreq_id got %0d exp 0", dreq_id); end
        n_vec++; if (occupancy !== 4'd1) begin n_mis++; $display("FAIL sm_occ1 got %0d exp 1", occupancy); end
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        n_vec++; if (dreq_vld !== 1'b0) begin n_mis++; $display("FAIL sm_dreq_done got %b exp 0", dreq_vld); end
        fill_vld = 1'b1; fill_id = 3'd0; fill_data = d;
        tick();
        fill_vld = 1'b0;
        n_vec++; if (resp_vld !== 1'b1) begin n_mis++; $display("FAIL sm_resp_vld got %b exp 1", resp_vld); end
        n_vec++; if (resp_txnid !== 5'd3 || resp_index !== 9'd5 || resp_way !== 1'b1) begin n_mis++; $display("FAIL sm_resp_fields got txn %0d idx %0d way %0d exp 3 5 1", resp_txnid, resp_index, resp_way); end
        n_vec++; if (resp_data !== d) begin n_mis++; $display("FAIL sm_resp_data got %h exp %h", resp_data, d); end
        n_vec++; if (fill_rdy !== 1'b0) begin n_mis++; $display("FAIL sm_fill_busy got %b exp 0", fill_rdy); end
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        n_vec++; if (resp_vld !== 1'b0 || occupancy !== 4'd0) begin n_mis++; $display("FAIL sm_done got vld %b occ %0d exp 0 0", resp_vld, occupancy); end
        n_vec++; if (fill_rdy !== 1'b1) begin n_mis++; $display("FAIL sm_fill_free got %b exp 1", fill_rdy); end
    endtask

    task automatic test_merge;
        logic [511:0] d;
        d = {8{64'h0123456789ABCDEF}};
        for (int k = 1; k <= 3; k++) begin
            set_alloc(17'h2B, 9'd7, 5'(k), 1'b0);
            tick();
        end
        alloc_vld = 1'b0;
        n_vec++; if (occupancy !== 4'd3) begin n_mis++; $display("FAIL mg_occ got %0d exp 3", occupancy); end
        n_vec++; if (dreq_vld !== 1'b1 || dreq_id !== 3'd0) begin n_mis++; $display("FAIL mg_dreq got vld %b id %0d exp 1 0", dreq_vld, dreq_id); end
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        n_vec++; if (dreq_vld !== 1'b0) begin n_mis++; $display("FAIL mg_single_dreq got %b exp 0", dreq_vld); end
        fill_vld = 1'b1; fill_id = 3'd0; fill_data = d;
        tick();
        fill_vld = 1'b0;
        resp_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            n_vec++; if (resp_vld !== 1'b1 || resp_txnid !== 5'(k) || resp_data !== d) begin n_mis++; $display("FAIL mg_resp%0d got vld %b txn %0d exp 1 %0d", k, resp_vld, resp_txnid, k); end
            n_vec++; if (fill_rdy !== 1'b0) begin n_mis++; $display("FAIL mg_fill_busy%0d got %b exp 0", k, fill_rdy); end
            tick();
        end
        resp_rdy = 1'b0;
        n_vec++; if (resp_vld !== 1'b0 || fill_rdy !== 1'b1 || occupancy !== 4'd0) begin n_mis++; $display("FAIL mg_done got resp %b fill_rdy %b occ %0d exp 0 1 0", resp_vld, fill_rdy, occupancy); end
    endtask

    task automatic test_full;
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (alloc_rdy !== 1'b1) begin n_mis++; $display("FAIL fu_rdy%0d got %b exp 1", k, alloc_rdy); end
            set_alloc(17'h100 + 17'(k), 9'(k), 5'(k), 1'(k));
            tick();
        end
        alloc_vld = 1'b0;
        n_vec++; if (alloc_rdy !== 1'b0 || occupancy !== 4'd8) begin n_mis++; $display("FAIL fu_full got rdy %b occ %0d exp 0 8", alloc_rdy, occupancy); end
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        n_vec++; if (dreq_id !== 3'd1 || dreq_addr !== {17'h101, 9'd1}) begin n_mis++; $display("FAIL fu_next_dreq got id %0d addr %h exp 1 %h", dreq_id, dreq_addr, {17'h101, 9'd1}); end
        fill_vld = 1'b1; fill_id = 3'd0; fill_data = 512'h77;
        tick();
        fill_vld = 1'b0;
        n_vec++; if (alloc_rdy !== 1'b0 || resp_txnid !== 5'd0) begin n_mis++; $display("FAIL fu_resp got rdy %b txn %0d exp 0 0", alloc_rdy, resp_txnid); end
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        n_vec++; if (alloc_rdy !== 1'b1 || occupancy !== 4'd7) begin n_mis++; $display("FAIL fu_freed got rdy %b occ %0d exp 1 7", alloc_rdy, occupancy); end
        set_alloc(17'h1FFFF, 9'h1FF, 5'd9, 1'b0);
        tick();
        alloc_vld = 1'b0;
        n_vec++; if (dreq_id !== 3'd0 || dreq_addr !== {17'h1FFFF, 9'h1FF}) begin n_mis++; $display("FAIL fu_reuse got id %0d addr %h exp 0 %h", dreq_id, dreq_addr, {17'h1FFFF, 9'h1FF}); end
        n_vec++; if (alloc_rdy !== 1'b0 || occupancy !== 4'd8) begin n_mis++; $display("FAIL fu_refull got rdy %b occ %0d exp 0 8", alloc_rdy, occupancy); end
        do_reset();
    endtask

    task automatic test_backpressure;
        logic [511:0] d;
        d = {32{16'hBEEF}};
        set_alloc(17'h55, 9'd3, 5'd4, 1'b0);
        tick();
        alloc_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (dreq_vld !== 1'b1 || dreq_addr !== {17'h55, 9'd3} || dreq_id !== 3'd0) begin n_mis++; $display("FAIL bp_dreq%0d got vld %b addr %h id %0d", k, dreq_vld, dreq_addr, dreq_id); end
            tick();
        end
        dreq_rdy = 1'b1;
        tick();
        dreq_rdy = 1'b0;
        fill_vld = 1'b1; fill_id = 3'd0; fill_data = d;
        tick();
        fill_data = 512'h0;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (resp_vld !== 1'b1 || resp_txnid !== 5'd4 || resp_index !== 9'd3 || resp_data !== d) begin n_mis++; $display("FAIL bp_resp%0d got vld %b txn %0d idx %0d", k, resp_vld, resp_txnid, resp_index); end
            n_vec++; if (fill_rdy !== 1'b0 || fill_err !== 1'b0) begin n_mis++; $display("FAIL bp_fill%0d got rdy %b err %b exp 0 0", k, fill_rdy, fill_err); end
            tick();
        end
        fill_vld = 1'b0;
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        n_vec++; if (resp_vld !== 1'b0 || fill_rdy !== 1'b1) begin n_mis++; $display("FAIL bp_done got resp %b fill_rdy %b exp 0 1", resp_vld, fill_rdy); end
    endtask

    task automatic test_fill_err;
        fill_vld = 1'b1; fill_id = 3'd4; fill_data = 512'h1;
        tick();
        fill_vld = 1'b0;
        n_vec++; if (fill_err !== 1'b1 || resp_vld !== 1'b0) begin n_mis++; $display("FAIL fe_idle got err %b resp %b exp 1 0", fill_err, resp_vld); end
        tick();
        n_vec++; if (fill_err !== 1'b0) begin n_mis++; $display("FAIL fe_pulse got %b exp 0", fill_err); end
        set_alloc(17'h33, 9'd9, 5'd6, 1'b1);
        tick();
        alloc_vld = 1'b0;
        fill_vld = 1'b1; fill_id = 3'd0;
        tick();
        fill_vld = 1'b0;
        n_vec++; if (fill_err !== 1'b1 || dreq_vld !== 1'b1 || resp_vld !== 1'b0 || fill_rdy !== 1'b1) begin n_mis++; $display("FAIL fe_waitreq got err %b dreq %b resp %b fill_rdy %b exp 1 1 0 1", fill_err, dreq_vld, resp_vld, fill_rdy); end
        do_reset();
    endtask

    task automatic test_reset_mid;
        set_alloc(17'h44, 9'd1, 5'd1, 1'b0);
        tick();
        set_alloc(17'h45, 9'd2, 5'd2, 1'b1);
        dreq_rdy = 1'b1;
        tick();
        alloc_vld = 1'b0;
        tick();
        dreq_rdy = 1'b0;
        n_vec++; if (occupancy !== 4'd2 || dreq_vld !== 1'b0) begin n_mis++; $display("FAIL rm_pre got occ %0d dreq %b exp 2 0", occupancy, dreq_vld); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (occupancy !== 4'd0 || alloc_rdy !== 1'b1 || fill_rdy !== 1'b1 || dreq_vld !== 1'b0 || resp_vld !== 1'b0 || fill_err !== 1'b0) begin n_mis++; $display("FAIL rm_outs got occ %0d ardy %b frdy %b dreq %b resp %b err %b", occupancy, alloc_rdy, fill_rdy, dreq_vld, resp_vld, fill_err); end
        fill_vld = 1'b1; fill_id = 3'd1; fill_data = 512'h5;
        tick();
        fill_vld = 1'b0;
        n_vec++; if (fill_err !== 1'b1 || resp_vld !== 1'b0) begin n_mis++; $display("FAIL rm_stale_fill got err %b resp %b exp 1 0", fill_err, resp_vld); end
    endtask

    initial begin
        rst = 1'b1; alloc_vld = 1'b0; alloc_tag = '0; alloc_index = '0; alloc_txnid = '0; alloc_way = '0;
        dreq_rdy = 1'b0; fill_vld = 1'b0; fill_id = '0; fill_data = '0; resp_rdy = 1'b0;
        tick();
        test_reset();
        test_single_miss();
        test_merge();
        test_full();
        test_backpressure();
        test_fill_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/icache_mshr_file.md
ICACHE_MSHR_FILE -- requirements
Module: icache_mshr_file

Interface
REQ-001 SHALL have parameters, one per line:
- ENTRY_NUM, 8, MSHR entry count (power of 2, 2..32); EIW = $clog2(ENTRY_NUM)
- TAG_WIDTH, 17, line tag bits
- INDEX_WIDTH, 9, set index bits
- TXNID_WIDTH, 5, upstream transaction id bits
- WAY_NUM, 2, cache ways; WW = max(1, $clog2(WAY_NUM))
- DATA_WIDTH, 512, line/fill data bits
- MERGE_EN, 1, 1 = secondary misses to a pending line merge onto the primary entry
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_vld  in  1  miss allocation request
- alloc_rdy  out  1  a free entry exists
- alloc_tag  in  TAG_WIDTH  miss tag
- alloc_index  in  INDEX_WIDTH  miss index
- alloc_txnid  in  TXNID_WIDTH  upstream txnid
- alloc_way  in  WW  victim way to fill
- dreq_vld  out  1  downstream read request
- dreq_rdy  in  1  downstream accepts
- dreq_addr  out  TAG_WIDTH+INDEX_WIDTH  {tag,index} of line
- dreq_id  out  EIW  issuing entry index
- fill_vld  in  1  downstream data return
- fill_rdy  out  1  fill buffer empty
- fill_id  in  EIW  entry index being filled
- fill_data  in  DATA_WIDTH  line data
- fill_err  out  1  one-cycle pulse: fill to entry not in WAIT_FILL
- resp_vld  out  1  completion to upstream/data RAM
- resp_rdy  in  1  consumer accepts
- resp_txnid  out  TXNID_WIDTH  completed txnid
- resp_index  out  INDEX_WIDTH  set index to write
- resp_way  out  WW  way to write
- resp_data  out  DATA_WIDTH  line data
- occupancy  out  $clog2(ENTRY_NUM+1)  valid entry count

Function
REQ-003 Each entry SHALL hold valid, tag, index, txnid, way, primary flag, parent index (EIW), state in {IDLE, WAIT_REQ, WAIT_FILL, RESP}.
REQ-004 alloc_rdy SHALL be 1 iff any entry is IDLE at start of cycle; handshake = alloc_vld & alloc_rdy; lowest-index IDLE entry allocated.
REQ-005 Merge: if MERGE_EN=1 and a valid primary entry in WAIT_REQ or WAIT_FILL matches {tag,index}, new entry SHALL be secondary (primary=0, parent=that entry, state WAIT_FILL, no downstream request); else primary, state WAIT_REQ.
REQ-006 Primary entry in RESP SHALL NOT be merge target; matching alloc becomes new primary.
REQ-007 dreq_vld SHALL be 1 iff any primary entry in WAIT_REQ; lowest index selected; dreq_addr/dreq_id stable while dreq_vld & !dreq_rdy; on handshake entry -> WAIT_FILL next cycle.
REQ-008 fill_rdy SHALL be 1 iff fill buffer empty; on fill_vld & fill_rdy with fill_id a primary in WAIT_FILL: data latched, that primary and all secondaries with parent=fill_id -> RESP next cycle.
REQ-009 Fill to entry not primary-WAIT_FILL SHALL be dropped, fill_err=1 next cycle for one cycle, no state change.
REQ-010 resp_vld SHALL be 1 iff any entry in RESP; lowest index first; resp_data from fill buffer; on resp handshake entry -> IDLE, valid=0 next cycle.
REQ-011 Fill buffer SHALL free (fill_rdy=1) the cycle after last RESP entry of its group handshakes; one fill group outstanding at a time.
REQ-012 Entry released in cycle N SHALL be allocatable in N+1 (no same-cycle reuse); alloc in same cycle as release of another entry permitted.
REQ-013 occupancy SHALL equal count of valid entries, updated one cycle after alloc/release; simultaneous alloc+release leaves it unchanged.
REQ-014 Latency: alloc to dreq_vld min 1 cycle; fill accept to resp_vld 1 cycle.

Reset
REQ-015 While rst=1 at clk edge: all entries IDLE/invalid, fill buffer empty; next cycle alloc_rdy=1, fill_rdy=1, dreq_vld=0, resp_vld=0, fill_err=0, occupancy=0, data outputs 0.
REQ-016 Reset mid-operation SHALL discard all pending entries and fill data; later fills for discarded ids raise fill_err.

Verification
REQ-017 Single miss: alloc tag=0x1A, index=5, txnid=3, way=1 -> dreq_vld next cycle, addr {0x1A,5}, id=0; fill id=0 -> resp txnid=3, index=5, way=1, data match; occupancy 1->0.
REQ-018 Merge: allocs txnid 1,2,3 same line -> one dreq only; one fill -> three responses in order txnid 1,2,3, then fill_rdy=1.
REQ-019 Full: ENTRY_NUM distinct allocs -> alloc_rdy=0, occupancy=8; one response released -> alloc_rdy=1 next cycle, new alloc gets freed index.
REQ-020 Backpressure: dreq_rdy=0 for 5 cycles -> dreq_addr/id stable; resp_rdy=0 -> resp outputs stable, fill_rdy stays 0.
REQ-021 Error/reset: fill id=4 with entry 4 IDLE -> fill_err single pulse, no resp; rst mid-WAIT_FILL -> all outputs reset values, occupancy=0.
